// File: rtl/keccak800_pkg.sv
// Shared constants and types for the Keccak-f[800] round-constant sequencer.
package keccak800_pkg;

  localparam int         KECCAK_NROUNDS = 22;
  localparam int         KECCAK_LANE_W  = 32;
  localparam logic [7:0] LFSR_INIT      = 8'h01;
  localparam int         RC_NBITS       = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } seq_state_t;

  // Lane bit positions (2^j)-1 that carry LFSR window bit j.
  localparam int RC_POS [RC_NBITS] = '{0, 1, 3, 7, 15, 31};

  // Which window bit drives lane bit b, or -1 if lane bit b is always zero.
  function automatic int rc_src(input int b);
    rc_src = -1;
    for (int j = 0; j < RC_NBITS; j++) begin
      if (RC_POS[j] == b) rc_src = j;
    end
  endfunction

endpackage

// File: rtl/keccak_rc_sequencer_if.sv
// Handshake bundle between the round-constant sequencer and its controller/datapath.
interface keccak_rc_sequencer_if #(
  parameter int LANE_W = keccak800_pkg::KECCAK_LANE_W
);
  logic              start;
  logic              ready;
  logic              rc_valid;
  logic              rc_ready;
  logic [LANE_W-1:0] rc;
  logic [4:0]        round_idx;
  logic              last;
  logic              done;

  modport master (
    output start, rc_ready,
    input  ready, rc_valid, rc, round_idx, last, done
  );

  modport slave (
    input  start, rc_ready,
    output ready, rc_valid, rc, round_idx, last, done
  );
endinterface

// File: rtl/keccak_next_round.sv
// Advances the 8-bit rc window by one round (seven LFSR steps).
module keccak_next_round (
  input  logic [7:0] cur,
  output logic [7:0] nxt
);
  // Window bit k holds rc(t+k); the sequence obeys
  // rc(t+8) = rc(t) ^ rc(t+4) ^ rc(t+5) ^ rc(t+6).
  logic [7:0] win;

  always_comb begin
    win = cur;
    for (int i = 0; i < 7; i++) begin
      win = {win[0] ^ win[4] ^ win[5] ^ win[6], win[7:1]};
    end
    nxt = win;
  end
endmodule

// File: rtl/keccak_rc_sequencer.sv
// Keccak-f[800] iota round-constant sequencer: IDLE -> RUN (one rc per round) -> DONE.
// Define KECCAK_RC_STALL_EN to honour rc_ready; otherwise one round is issued per cycle.
module keccak_rc_sequencer
  import keccak800_pkg::*;
#(
  parameter int NROUNDS = keccak800_pkg::KECCAK_NROUNDS,
  parameter int LANE_W  = keccak800_pkg::KECCAK_LANE_W
) (
  input logic                  clk,
  input logic                  rst_n,
  keccak_rc_sequencer_if.slave bus
);

  localparam logic [4:0] LAST_IDX = 5'(NROUNDS - 1);

  seq_state_t        state_q, state_d;
  logic [4:0]        round_q, round_d;
  logic [7:0]        lfsr_q, lfsr_d, lfsr_next;
  logic              adv_ready;
  logic              ready_w, rc_valid_w, done_w;
  logic [LANE_W-1:0] rc_w;

`ifdef KECCAK_RC_STALL_EN
  assign adv_ready = bus.rc_ready;
`else
  logic unused_rc_ready;
  assign unused_rc_ready = bus.rc_ready;
  assign adv_ready       = 1'b1;
`endif

  keccak_next_round u_next_round (
    .cur (lfsr_q),
    .nxt (lfsr_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      lfsr_q  <= LFSR_INIT;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    lfsr_d     = lfsr_q;
    ready_w    = 1'b0;
    rc_valid_w = 1'b0;
    done_w     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready_w = 1'b1;
        if (bus.start) begin
          state_d = ST_RUN;
          round_d = '0;
          lfsr_d  = LFSR_INIT;
        end
      end
      ST_RUN: begin
        rc_valid_w = 1'b1;
        if (adv_ready) begin
          if (round_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            round_d = round_q + 5'd1;
            lfsr_d  = lfsr_next;
          end
        end
      end
      ST_DONE: begin
        done_w  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only lane bits (2^j)-1 are populated; the rest of the lane is zero.
  for (genvar b = 0; b < LANE_W; b++) begin : g_rc
    if (rc_src(b) >= 0) begin : g_tap
      assign rc_w[b] = lfsr_q[rc_src(b)];
    end else begin : g_zero
      assign rc_w[b] = 1'b0;
    end
  end

  assign bus.ready     = ready_w;
  assign bus.rc_valid  = rc_valid_w;
  assign bus.done      = done_w;
  assign bus.rc        = rc_w;
  assign bus.round_idx = round_q;
  assign bus.last      = rc_valid_w && (round_q == LAST_IDX);

endmodule

// File: tb/tb_keccak_rc_sequencer.sv
// Scoreboard bench for keccak_rc_sequencer: stimulus queues expected rounds, a monitor checks them.
module tb_keccak_rc_sequencer;

  localparam int NR = 22;

  // Low 32 bits of the standard Keccak round constants RC[0..21].
  localparam logic [31:0] GOLD [NR] = '{
    32'h00000001, 32'h00008082, 32'h0000808A, 32'h80008000,
    32'h0000808B, 32'h80000001, 32'h80008081, 32'h00008009,
    32'h0000008A, 32'h00000088, 32'h80008009, 32'h8000000A,
    32'h8000808B, 32'h0000008B, 32'h00008089, 32'h00008003,
    32'h00008002, 32'h00000080, 32'h0000800A, 32'h8000000A,
    32'h80008081, 32'h00008080
  };

  typedef struct {
    logic        is_done;
    logic [4:0]  idx;
    logic [31:0] rc;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   last_hs_cyc = -10;
  exp_t sb [$];
  exp_t mon_e;
  logic hs_ready;

  keccak_rc_sequencer_if #(.LANE_W(32)) bus ();

  keccak_rc_sequencer #(.NROUNDS(NR), .LANE_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef KECCAK_RC_STALL_EN
  assign hs_ready = bus.rc_ready;
`else
  assign hs_ready = 1'b1;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_perm();
    for (int r = 0; r < NR; r++) begin
      sb.push_back('{is_done: 1'b0, idx: 5'(r), rc: GOLD[r], last: (r == NR - 1)});
    end
    sb.push_back('{is_done: 1'b1, idx: 5'd0, rc: 32'h0, last: 1'b0});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, {31'b0, bus.done}, 32'd1);
  endtask

  // Monitor: every handshake and every done pulse pops one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.rc_valid && hs_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_round: round_idx %0d rc %h with empty scoreboard", bus.round_idx, bus.rc);
        end else begin
          mon_e = sb.pop_front();
          check("hs_is_round", {31'b0, mon_e.is_done}, 32'd0);
          check("round_idx", {27'b0, bus.round_idx}, {27'b0, mon_e.idx});
          check("rc", bus.rc, mon_e.rc);
          check("last", {31'b0, bus.last}, {31'b0, mon_e.last});
          check("ready_low_in_run", {31'b0, bus.ready}, 32'd0);
          if (bus.last) last_hs_cyc = cyc;
        end
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_done: done pulse with empty scoreboard");
        end else begin
          mon_e = sb.pop_front();
          check("done_in_order", {31'b0, mon_e.is_done}, 32'd1);
          check("done_latency", cyc, last_hs_cyc + 1);
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.rc_ready = 1'b1;
    #12;
    check("rst_ready", {31'b0, bus.ready}, 32'd1);
    check("rst_rc_valid", {31'b0, bus.rc_valid}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_round_idx", {27'b0, bus.round_idx}, 32'd0);
    check("rst_rc", bus.rc, 32'h00000001);

    // Basic run: start raised together with reset release, taken on the next edge.
    push_perm();
    #10;
    rst_n     = 1'b1;
    bus.start = 1'b1;
    tick();
    check("first_latency_valid", {31'b0, bus.rc_valid}, 32'd1);
    check("first_latency_idx", {27'b0, bus.round_idx}, 32'd0);
    bus.start = 1'b0;
    wait_done("run1");
    tick();
    check("post_done_ready", {31'b0, bus.ready}, 32'd1);
    check("done_one_cycle", {31'b0, bus.done}, 32'd0);

    // start held high: exactly one permutation, then one more after IDLE.
    push_perm();
    push_perm();
    bus.start = 1'b1;
    tick();
    wait_done("held1");
    tick();
    check("held_idle_ready", {31'b0, bus.ready}, 32'd1);
    check("held_idle_valid", {31'b0, bus.rc_valid}, 32'd0);
    tick();
    check("held_restart_valid", {31'b0, bus.rc_valid}, 32'd1);
    check("held_restart_idx", {27'b0, bus.round_idx}, 32'd0);
    bus.start = 1'b0;
    wait_done("held2");
    tick();

`ifdef KECCAK_RC_STALL_EN
    // Stall for five cycles at round 3; rc and round_idx must hold.
    push_perm();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 40 && bus.round_idx != 5'd3; n++) tick();
    bus.rc_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check("stall_rc", bus.rc, 32'h80008000);
      check("stall_idx", {27'b0, bus.round_idx}, 32'd3);
      check("stall_valid", {31'b0, bus.rc_valid}, 32'd1);
    end
    bus.rc_ready = 1'b1;
    wait_done("stall");
    tick();
`endif

    // Reset at round 10: outputs clear at once and no done is produced.
    push_perm();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 40 && bus.round_idx != 5'd10; n++) tick();
    check("reached_round10", {27'b0, bus.round_idx}, 32'd10);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, bus.rc_valid}, 32'd0);
    check("midrst_ready", {31'b0, bus.ready}, 32'd1);
    check("midrst_idx", {27'b0, bus.round_idx}, 32'd0);
    check("midrst_rc", bus.rc, 32'h00000001);
    check("midrst_done", {31'b0, bus.done}, 32'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("no_done_after_rst", {31'b0, bus.done}, 32'd0);
    end

    push_perm();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart_idx", {27'b0, bus.round_idx}, 32'd0);
    check("restart_rc", bus.rc, 32'h00000001);
    wait_done("restart");
    tick();
    tick();

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
